// File: rtl/call_stack_param_pkg.sv
// ---------------------------------------------------------------------------
// call_stack_param_pkg
// Shared definitions for the return-address stack and the logic around it
// (ID-stage controller, hazard unit).
//   OVF_SATURATE / OVF_WRAP : values for the OVF_MODE parameter
//   ptrWidth / cntWidth     : sizing helpers for stack pointer and occupancy
//   stack_op_e              : opcode-independent stack operation encoding
// ---------------------------------------------------------------------------
package call_stack_param_pkg;

    localparam int OVF_SATURATE = 0;
    localparam int OVF_WRAP     = 1;

    // Pointer addresses DEPTH slots; keep at least one bit for tiny stacks.
    function automatic int ptrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy must be able to represent 0..DEPTH inclusive.
    function automatic int cntWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

    typedef enum logic [1:0] {
        OP_NOP     = 2'd0,
        OP_PUSH    = 2'd1,
        OP_POP     = 2'd2,
        OP_REPLACE = 2'd3
    } stack_op_e;

endpackage

// File: rtl/call_stack_ram.sv
// ---------------------------------------------------------------------------
// call_stack_ram
// DEPTH x DATA_W register array backing the return-address stack.
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset, clears every entry
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : asynchronous read address
//   o_rdata  : entry at i_raddr
// ---------------------------------------------------------------------------
module call_stack_ram #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/call_stack_param.sv
// ---------------------------------------------------------------------------
// call_stack_param
// Parametrised return-address stack with checkpoint/restore for squashes.
//   clk, rst             : rising-edge clock, async active-low reset
//   push, pop, writeData : stack operation request and address to push
//   readData             : current top of stack (0 when empty)
//   ckpt, restore        : snapshot / roll back sp and count
//   clrErr               : clear sticky overflow/underflow
//   count, empty, full   : occupancy status
//   overflow, underflow  : sticky error flags
// DEPTH must be a power of two so pointer arithmetic wraps naturally.
// ---------------------------------------------------------------------------
module call_stack_param
    import call_stack_param_pkg::*;
#(
    parameter int DATA_W   = 12,
    parameter int DEPTH    = 8,
    parameter int OVF_MODE = OVF_SATURATE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DATA_W-1:0]            writeData,
    output logic [DATA_W-1:0]            readData,
    input  logic                         ckpt,
    input  logic                         restore,
    input  logic                         clrErr,
    output logic [cntWidth(DEPTH)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PTR_W = ptrWidth(DEPTH);
    localparam int CNT_W = cntWidth(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  r_sp;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_snapSp;
    logic [CNT_W-1:0]  r_snapCount;
    logic              r_overflow;
    logic              r_underflow;

    stack_op_e         w_op;
    logic              w_empty;
    logic              w_full;
    logic [PTR_W-1:0]  w_top;
    logic              w_we;
    logic [PTR_W-1:0]  w_waddr;
    logic [DATA_W-1:0] w_rdData;
    logic [PTR_W-1:0]  w_spNext;
    logic [CNT_W-1:0]  w_countNext;
    logic              w_setOvf;
    logic              w_setUnf;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_FULL);
    assign w_top   = r_sp - PTR_ONE;

    // Restore masks push/pop entirely. Push+pop on an empty stack has no
    // top to replace, so it degrades to a plain push.
    always_comb begin
        w_op = OP_NOP;
        if (!restore) begin
            if (push && pop && !w_empty) begin
                w_op = OP_REPLACE;
            end else if (push) begin
                w_op = OP_PUSH;
            end else if (pop) begin
                w_op = OP_POP;
            end
        end
    end

    // Next pointer/count, RAM write and flag-set conditions.
    always_comb begin
        w_we        = 1'b0;
        w_waddr     = r_sp;
        w_spNext    = r_sp;
        w_countNext = r_count;
        w_setOvf    = 1'b0;
        w_setUnf    = 1'b0;
        if (restore) begin
            w_spNext    = r_snapSp;
            w_countNext = r_snapCount;
        end
        case (w_op)
            OP_PUSH: begin
                // pop alongside push only reaches here when empty
                w_setUnf = pop;
                if (!w_full) begin
                    w_we        = 1'b1;
                    w_spNext    = r_sp + PTR_ONE;
                    w_countNext = r_count + CNT_ONE;
                end else begin
                    w_setOvf = 1'b1;
                    if (OVF_MODE == OVF_WRAP) begin
                        w_we     = 1'b1;
                        w_spNext = r_sp + PTR_ONE;
                    end
                end
            end
            OP_POP: begin
                if (!w_empty) begin
                    w_spNext    = r_sp - PTR_ONE;
                    w_countNext = r_count - CNT_ONE;
                end else begin
                    w_setUnf = 1'b1;
                end
            end
            OP_REPLACE: begin
                w_we    = 1'b1;
                w_waddr = w_top;
            end
            default: begin
            end
        endcase
    end

    // State update. The snapshot takes pre-edge values; restore wins over
    // a simultaneous ckpt so the old snapshot survives. Flag set beats clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sp        <= '0;
            r_count     <= '0;
            r_snapSp    <= '0;
            r_snapCount <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_sp    <= w_spNext;
            r_count <= w_countNext;
            if (ckpt && !restore) begin
                r_snapSp    <= r_sp;
                r_snapCount <= r_count;
            end
            if (w_setOvf) begin
                r_overflow <= 1'b1;
            end else if (clrErr) begin
                r_overflow <= 1'b0;
            end
            if (w_setUnf) begin
                r_underflow <= 1'b1;
            end else if (clrErr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    call_stack_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (writeData),
        .i_raddr (w_top),
        .o_rdata (w_rdData)
    );

    assign readData  = w_empty ? '0 : w_rdData;
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_call_stack_param.sv
// ---------------------------------------------------------------------------
// tb_call_stack_param
// Drives a saturating and a wrapping instance with identical stimulus and
// scores both against an array-based stack model.
// ---------------------------------------------------------------------------
module tb_call_stack_param;
    import call_stack_param_pkg::*;

    localparam int D = 8;

    typedef struct packed {
        logic [11:0] rd;
        logic [3:0]  cnt;
        logic        emp;
        logic        ful;
        logic        ovf;
        logic        unf;
    } obs_t;

    typedef struct packed {
        obs_t s;
        obs_t w;
    } pair_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic        ckpt = 1'b0;
    logic        restore = 1'b0;
    logic        clrErr = 1'b0;
    logic [11:0] writeData = '0;

    logic [11:0] rdS, rdW;
    logic [3:0]  cntS, cntW;
    logic        emptyS, emptyW, fullS, fullW, ovfS, ovfW, unfS, unfW;
    obs_t        obsS, obsW;

    int vectors = 0;
    int miscompares = 0;

    pair_t expQ[$];

    // Abstract model state, index 0 = saturate, 1 = wrap
    int mMem [2][D];
    int mSp [2];
    int mCnt [2];
    int mSnapSp [2];
    int mSnapCnt [2];
    bit mOvf [2];
    bit mUnf [2];

    always #5 clk = ~clk;

    call_stack_param #(.DATA_W(12), .DEPTH(D), .OVF_MODE(OVF_SATURATE)) dutSat (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .writeData(writeData),
        .readData(rdS), .ckpt(ckpt), .restore(restore), .clrErr(clrErr),
        .count(cntS), .empty(emptyS), .full(fullS), .overflow(ovfS), .underflow(unfS)
    );

    call_stack_param #(.DATA_W(12), .DEPTH(D), .OVF_MODE(OVF_WRAP)) dutWrap (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .writeData(writeData),
        .readData(rdW), .ckpt(ckpt), .restore(restore), .clrErr(clrErr),
        .count(cntW), .empty(emptyW), .full(fullW), .overflow(ovfW), .underflow(unfW)
    );

    assign obsS = {rdS, cntS, emptyS, fullS, ovfS, unfS};
    assign obsW = {rdW, cntW, emptyW, fullW, ovfW, unfW};

    function automatic void modelReset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < D; i++) mMem[m][i] = 0;
            mSp[m] = 0; mCnt[m] = 0; mSnapSp[m] = 0; mSnapCnt[m] = 0;
            mOvf[m] = 1'b0; mUnf[m] = 1'b0;
        end
    endfunction

    // One clock edge of the stack rules for mode m
    function automatic void modelStep(int m, bit pu, bit po, bit ck, bit re, bit ce, int wd);
        int preSp = mSp[m];
        int preCnt = mCnt[m];
        bit setO = 1'b0;
        bit setU = 1'b0;
        if (re) begin
            mSp[m] = mSnapSp[m];
            mCnt[m] = mSnapCnt[m];
        end else if (pu && po && preCnt > 0) begin
            mMem[m][(preSp + D - 1) % D] = wd;
        end else if (pu) begin
            if (po) setU = 1'b1;
            if (preCnt < D) begin
                mMem[m][preSp] = wd;
                mSp[m] = (preSp + 1) % D;
                mCnt[m] = preCnt + 1;
            end else begin
                setO = 1'b1;
                if (m == 1) begin
                    mMem[m][preSp] = wd;
                    mSp[m] = (preSp + 1) % D;
                end
            end
        end else if (po) begin
            if (preCnt > 0) begin
                mSp[m] = (preSp + D - 1) % D;
                mCnt[m] = preCnt - 1;
            end else begin
                setU = 1'b1;
            end
        end
        if (ck && !re) begin
            mSnapSp[m] = preSp;
            mSnapCnt[m] = preCnt;
        end
        mOvf[m] = setO ? 1'b1 : (ce ? 1'b0 : mOvf[m]);
        mUnf[m] = setU ? 1'b1 : (ce ? 1'b0 : mUnf[m]);
    endfunction

    function automatic obs_t modelObs(int m);
        obs_t o;
        o.rd  = (mCnt[m] == 0) ? 12'h000 : 12'(mMem[m][(mSp[m] + D - 1) % D]);
        o.cnt = 4'(mCnt[m]);
        o.emp = (mCnt[m] == 0);
        o.ful = (mCnt[m] == D);
        o.ovf = mOvf[m];
        o.unf = mUnf[m];
        return o;
    endfunction

    task automatic compareObs(input string name, input obs_t act, input obs_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got rd=%h cnt=%0d e=%b f=%b o=%b u=%b, want rd=%h cnt=%0d e=%b f=%b o=%b u=%b",
                     name, act.rd, act.cnt, act.emp, act.ful, act.ovf, act.unf,
                     exp.rd, exp.cnt, exp.emp, exp.ful, exp.ovf, exp.unf);
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; expectation is queued for the monitor
    task automatic applyStimulus(input bit pu, input bit po, input bit ck, input bit re,
                                 input bit ce, input logic [11:0] wd);
        pair_t p;
        @(negedge clk);
        push = pu; pop = po; ckpt = ck; restore = re; clrErr = ce; writeData = wd;
        modelStep(0, pu, po, ck, re, ce, int'(wd));
        modelStep(1, pu, po, ck, re, ce, int'(wd));
        p.s = modelObs(0);
        p.w = modelObs(1);
        expQ.push_back(p);
        @(posedge clk);
        #2;
        push = 1'b0; pop = 1'b0; ckpt = 1'b0; restore = 1'b0; clrErr = 1'b0;
    endtask

    // Monitor: every cycle with a queued expectation is scored
    initial begin
        pair_t p;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                p = expQ.pop_front();
                compareObs("sbSat", obsS, p.s);
                compareObs("sbWrap", obsW, p.w);
            end
        end
    end

    initial begin
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        compareObs("resetSat", obsS, modelObs(0));
        compareObs("resetWrap", obsW, modelObs(1));
        @(negedge clk);
        rst = 1'b1;

        // basic push/pop
        applyStimulus(1, 0, 0, 0, 0, 12'h101);
        applyStimulus(1, 0, 0, 0, 0, 12'h202);
        applyStimulus(1, 0, 0, 0, 0, 12'h303);
        checkOutput("push3Count", 32'(cntS), 32'd3);
        checkOutput("push3Top", 32'(rdS), 32'h303);
        applyStimulus(0, 1, 0, 0, 0, 12'h000);
        applyStimulus(0, 1, 0, 0, 0, 12'h000);
        checkOutput("pop2Top", 32'(rdS), 32'h101);
        checkOutput("pop2Empty", 32'(emptyS), 32'd0);
        applyStimulus(0, 1, 0, 0, 0, 12'h000);

        // fill past capacity in both modes
        for (int i = 1; i <= 9; i++) applyStimulus(1, 0, 0, 0, 0, 12'(i));
        checkOutput("satFullTop", 32'(rdS), 32'h008);
        checkOutput("satOvf", 32'(ovfS), 32'd1);
        checkOutput("wrapFullTop", 32'(rdW), 32'h009);
        checkOutput("wrapFullCount", 32'(cntW), 32'd8);
        applyStimulus(0, 0, 0, 0, 1, 12'h000);
        checkOutput("ovfCleared", 32'(ovfW), 32'd0);
        for (int i = 0; i < 7; i++) applyStimulus(0, 1, 0, 0, 0, 12'h000);
        checkOutput("wrapLastTop", 32'(rdW), 32'h002);
        applyStimulus(0, 1, 0, 0, 0, 12'h000);
        checkOutput("wrapDrainedRd", 32'(rdW), 32'h000);

        // underflow cases
        applyStimulus(0, 1, 0, 0, 0, 12'h000);
        checkOutput("unfSet", 32'(unfS), 32'd1);
        applyStimulus(1, 1, 0, 0, 0, 12'h0AA);
        checkOutput("pushPopEmptyTop", 32'(rdS), 32'h0AA);
        applyStimulus(0, 1, 0, 0, 1, 12'h000);

        // checkpoint / restore
        applyStimulus(1, 0, 0, 0, 0, 12'h111);
        applyStimulus(0, 0, 1, 0, 0, 12'h000);
        applyStimulus(1, 0, 0, 0, 0, 12'h222);
        applyStimulus(1, 0, 0, 0, 0, 12'h333);
        applyStimulus(0, 0, 0, 1, 0, 12'h000);
        checkOutput("restoreCount", 32'(cntS), 32'd1);
        checkOutput("restoreTop", 32'(rdS), 32'h111);
        applyStimulus(1, 0, 0, 0, 0, 12'h444);
        applyStimulus(0, 0, 1, 1, 0, 12'h000);
        applyStimulus(1, 0, 0, 0, 0, 12'h555);
        applyStimulus(0, 0, 0, 1, 0, 12'h000);
        checkOutput("snapKeptCount", 32'(cntW), 32'd1);

        // tail-call replace
        applyStimulus(1, 0, 0, 0, 0, 12'h222);
        applyStimulus(1, 1, 0, 0, 0, 12'h3FF);
        checkOutput("replaceCount", 32'(cntS), 32'd2);
        checkOutput("replaceTop", 32'(rdS), 32'h3FF);

        // asynchronous reset between edges
        #1;
        rst = 1'b0;
        #1;
        modelReset();
        compareObs("asyncRstSat", obsS, modelObs(0));
        compareObs("asyncRstWrap", obsW, modelObs(1));
        @(negedge clk);
        rst = 1'b1;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(99) < 50), ($urandom_range(99) < 40),
                          ($urandom_range(99) < 10), ($urandom_range(99) < 8),
                          ($urandom_range(99) < 10), 12'($urandom));
        end

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
        #2;
        checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/call_stack_param.md
Name: call_stack_param

Overview:
Parametrised hardware return-address stack for the pipelined processor, replacing the fixed single-depth call/return stack in the ID stage. It stores PC+1 values on call (push) and supplies the return target on return (pop). Beyond plain push/pop, it adds:
- configurable width, depth and overflow mode
- full/empty status and sticky error flags
- a checkpoint/restore pair, so the hazard unit can undo stack effects of flushed (squashed) instructions.

Parameters:
DATA_W, 12, width of each stored return address (PC width).
DEPTH, 8, number of entries; power of two, >= 2.
OVF_MODE, 0, 0 = saturate (push to full stack rejected); 1 = wrap (push to full stack overwrites oldest entry).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
push  in  1  push writeData this cycle.
pop  in  1  pop top entry this cycle.
writeData  in  DATA_W  address to push (IF_ID PC+1).
readData  out  DATA_W  current top of stack, combinational from registered state; 0 when empty.
ckpt  in  1  snapshot sp and count.
restore  in  1  return sp and count to last snapshot.
clrErr  in  1  clear sticky error flags.
count  out  CNT_W  occupancy 0..DEPTH, CNT_W = clog2(DEPTH+1).
empty  out  1  count == 0.
full  out  1  count == DEPTH.
overflow  out  1  sticky: a push occurred while full.
underflow  out  1  sticky: a pop occurred while empty.

Behaviour:
- Reset (rst low, asynchronous): all cleared. This covers sp, count, snapshot sp, snapshot count, all entries, overflow and underflow. Outputs: readData=0, count=0, empty=1, full=0.
- sp points to the next free slot, modulo DEPTH. Top entry = mem[sp-1 mod DEPTH].
- Timing: all updates take effect on the rising clk edge. readData/count/empty/full reflect the new state in the following cycle; there is no other latency.
- Priority per cycle: restore > (push/pop) ; ckpt and clrErr evaluate in parallel with these.
- restore: sp <= snapSp, count <= snapCount. push/pop are ignored that cycle; entries are not modified.
  - In wrap mode, entries overwritten since the snapshot are not recovered. Software/hazard logic accepts this.
- ckpt: the snapshot captures the pre-edge sp/count, even if push/pop occur in the same cycle. If ckpt and restore are both asserted, restore executes and the snapshot is left unchanged.
- push only, not full: mem[sp] <= writeData; sp+1; count+1.
- push only, full:
  - OVF_MODE=0: no state change; overflow <= 1.
  - OVF_MODE=1: mem[sp] <= writeData; sp+1; count stays DEPTH; overflow <= 1.
- pop only, not empty: sp-1; count-1. The entry is not cleared.
- pop only, empty: no state change; underflow <= 1.
- push and pop, not empty: replace top, i.e. mem[sp-1] <= writeData. sp and count are unchanged. This is a tail call and never sets overflow, even when full.
- push and pop, empty: acts as push only; underflow <= 1.
- Pointer arithmetic wraps modulo DEPTH in both modes. count never exceeds DEPTH and never goes below 0.
- Sticky flags: set condition wins over clrErr in the same cycle. Otherwise clrErr clears both flags on the next edge.

Decomposition:
- Shared package holds:
  - OVF_SATURATE=0 and OVF_WRAP=1 constants
  - pointer/count width helper functions (clog2-based)
  - opcode-independent stack-op encoding {NOP, PUSH, POP, REPLACE}, used by the controller and hazard unit.
- One sub-module: call_stack_ram, a DEPTH x DATA_W register array with one synchronous write port and one asynchronous read port, reset to 0. Pointer, count, snapshot and flag logic stays in call_stack_param.

Test Plan:
- Reset, then push 0x101, 0x202, 0x303 on consecutive cycles -> count=3, readData=0x303. Then pop twice -> readData=0x101, count=1, empty=0.
- DEPTH=8, OVF_MODE=0: push 0x001..0x008, then push 0x009 -> full=1, count=8, readData=0x008, overflow=1. Then assert clrErr -> overflow=0 on the next cycle.
- DEPTH=8, OVF_MODE=1: push 0x001..0x009 -> count=8, readData=0x009, overflow=1. Then pop 8 times -> last readData before empty = 0x002, then empty=1, readData=0.
- Empty stack: pop -> underflow=1, count=0. Same cycle push 0x0AA + pop on empty -> count=1, readData=0x0AA, underflow=1.
- Push 0x111, ckpt, push 0x222, push 0x333, restore -> count=1, readData=0x111. Also: ckpt+restore asserted together leaves the snapshot unchanged.
- Stack holding 0x111,0x222: push 0x3FF + pop together -> count=2, readData=0x3FF. Then assert rst low mid-sequence (asynchronously, between edges) -> immediately count=0, empty=1, flags=0.
